// File: rtl/dsp_port_pkg.sv
// Shared definitions for the DSP port bridge: port address map and mailbox states.
package dsp_port_pkg;

    localparam logic [2:0] PA_MBOX = 3'd0;
    localparam logic [2:0] PA_STAT = 3'd1;
    localparam logic [2:0] PA_ROM  = 3'd2;

    typedef enum logic {
        MB_EMPTY = 1'b0,
        MB_FULL  = 1'b1
    } mbox_state_e;

endpackage

// File: rtl/dsp_mailbox.sv
// Single-entry host-to-DSP mailbox; a write is accepted when the slot is free or
// is being drained in the same cycle, otherwise it is dropped.
module dsp_mailbox
    import dsp_port_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          host_wr_i,
    input  logic [DW-1:0] host_d_i,
    input  logic          rd_i,
    output logic [DW-1:0] data_o,
    output logic          busy_o
);

    mbox_state_e   state_q, state_d;
    logic [DW-1:0] data_q, data_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= MB_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // A read that coincides with a host write hands out the old word and keeps the slot full.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            MB_EMPTY: begin
                if (host_wr_i) begin
                    state_d = MB_FULL;
                    data_d  = host_d_i;
                end
            end
            MB_FULL: begin
                if (host_wr_i && rd_i) begin
                    data_d = host_d_i;
                end else if (rd_i) begin
                    state_d = MB_EMPTY;
                end
            end
            default: state_d = MB_EMPTY;
        endcase
    end

    assign data_o = data_q;
    assign busy_o = (state_q == MB_FULL);

endmodule

// File: rtl/dsp_port_bridge.sv
// DSP port bridge: output latches, auto-incrementing sample ROM address built from
// OUT[1]:OUT[0], and a host mailbox, all behind a small strobed port.
module dsp_port_bridge
    import dsp_port_pkg::*;
#(
    parameter int DW       = 16,
    parameter int ROM_AW   = 20,
    parameter int NOUT     = 8,
    parameter int AUTO_INC = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ce_r_i,
    input  logic [2:0]         a_i,
    input  logic [DW-1:0]      do_i,
    input  logic               we_n_i,
    input  logic               den_n_i,
    output logic [DW-1:0]      di_o,
    output logic [NOUT*DW-1:0] out_q_o,
    output logic [ROM_AW-1:0]  rom_a_o,
    input  logic [DW-1:0]      rom_do_i,
    input  logic               host_wr_i,
    input  logic [DW-1:0]      host_d_i,
    output logic               host_busy_o
);

    logic [DW-1:0]     out_q [NOUT];
    logic [DW-1:0]     out_d [NOUT];
    logic              wr_ev, rd_ev;
    logic [2*DW-1:0]   addr_cat, addr_next;
    logic [ROM_AW-1:0] rom_addr;
    logic [DW-1:0]     mbox_data;
    logic              mbox_busy;

    assign wr_ev    = ce_r_i & ~we_n_i;
    assign rd_ev    = ce_r_i & ~den_n_i;
    assign addr_cat = {out_q[1], out_q[0]};
    assign rom_addr = addr_cat[ROM_AW-1:0];

    // Only the low ROM_AW bits count; upper OUT[1] bits ride through untouched.
    always_comb begin
        addr_next               = addr_cat;
        addr_next[ROM_AW-1:0]   = rom_addr + {{(ROM_AW-1){1'b0}}, 1'b1};
    end

    always_comb begin
        for (int k = 0; k < NOUT; k++) begin
            out_d[k] = out_q[k];
        end
        if (AUTO_INC != 0 && rd_ev && a_i == PA_ROM) begin
            out_d[0] = addr_next[DW-1:0];
            out_d[1] = addr_next[2*DW-1:DW];
        end
        for (int k = 0; k < NOUT; k++) begin
            if (wr_ev && a_i == 3'(k)) begin
                out_d[k] = do_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NOUT; k++) begin
            if (rst_i) begin
                out_q[k] <= '0;
            end else begin
                out_q[k] <= out_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NOUT; k++) begin
            out_q_o[k*DW +: DW] = out_q[k];
        end
    end

    assign rom_a_o = rom_addr;

    always_comb begin
        case (a_i)
            PA_MBOX: di_o = mbox_data;
            PA_STAT: di_o = {{(DW-1){1'b0}}, mbox_busy};
            PA_ROM:  di_o = rom_do_i;
            default: di_o = '0;
        endcase
    end

    dsp_mailbox #(.DW(DW)) u_mailbox (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .host_wr_i (host_wr_i),
        .host_d_i  (host_d_i),
        .rd_i      (rd_ev && (a_i == PA_MBOX)),
        .data_o    (mbox_data),
        .busy_o    (mbox_busy)
    );

    assign host_busy_o = mbox_busy;

endmodule
